// File: rtl/inst_rom_loader.sv
// inst_rom_loader: write-side loader for the instruction ROM.
// Parses a byte stream: count low byte, count high byte (word count N), then 4*N
// payload bytes packed little-endian into 32-bit words written at addresses 0..N-1.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_byte, i_byte_vld  host byte and its one-cycle valid strobe
//   i_reload            one-cycle pulse: abort/clear and return to idle
//   o_wdata, o_we,      ROM write port (registered, one-cycle write pulse)
//   o_waddr
//   o_init_done         image fully loaded (level)
//   o_busy              frame in progress
//   o_err               load failed (sticky until reload or reset)
module inst_rom_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_vld,
  input  logic              i_reload,
  output logic [31:0]       o_wdata,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic              o_init_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned IdxW = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StCntHi,
    StData,
`ifdef INST_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone,
    StErr
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       n_full;
  logic [IdxW-1:0]   widx_nxt;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  assign n_full   = {i_byte, cnt_q[7:0]};
  assign widx_nxt = widx_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    we_d    = 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (i_reload) begin
      // Reload wins over a coincident byte; ROM write data/address are left alone.
      state_d = StIdle;
      cnt_d   = '0;
      widx_d  = '0;
      bidx_d  = '0;
      buf_d   = '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_byte_vld) begin
            cnt_d[7:0] = i_byte;
            state_d    = StCntHi;
          end
        end
        StCntHi: begin
          if (i_byte_vld) begin
            cnt_d[15:8] = i_byte;
            widx_d      = '0;
            bidx_d      = '0;
            if (n_full == 16'd0 || n_full > 16'(DEPTH)) state_d = StErr;
            else                                         state_d = StData;
          end
        end
        StData: begin
`ifndef INST_LOADER_CHECKSUM_EN
          // All words written: spend the write-pulse cycle here so init_done
          // rises only after o_we has dropped.
          if (16'(widx_q) == cnt_q) begin
            state_d = StDone;
          end else
`endif
          if (i_byte_vld) begin
`ifdef INST_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ i_byte;
`endif
            bidx_d = bidx_q + 2'd1;
            unique case (bidx_q)
              2'd0: buf_d[7:0]   = i_byte;
              2'd1: buf_d[15:8]  = i_byte;
              2'd2: buf_d[23:16] = i_byte;
              default: begin
                wdata_d = {i_byte, buf_q};
                waddr_d = widx_q[ADDR_W-1:0];
                we_d    = 1'b1;
                widx_d  = widx_nxt;
`ifdef INST_LOADER_CHECKSUM_EN
                // Enter CHK right away so a back-to-back checksum byte is not lost.
                if (16'(widx_nxt) == cnt_q) state_d = StChk;
`endif
              end
            endcase
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        StChk: begin
          if (i_byte_vld) state_d = (i_byte == csum_q) ? StDone : StErr;
        end
`endif
        StDone:  ;
        StErr:   ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign o_wdata     = wdata_q;
  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_init_done = (state_q == StDone);
  assign o_err       = (state_q == StErr);
`ifdef INST_LOADER_CHECKSUM_EN
  assign o_busy      = (state_q == StCntHi) || (state_q == StData) || (state_q == StChk);
`else
  assign o_busy      = (state_q == StCntHi) || (state_q == StData);
`endif

endmodule
